// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts a command
// byte out LSB first with odd parity on device clock falling edges and checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       send,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // One shared timer serves both the inhibit interval and the device-clock timeout.
  localparam int unsigned TMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                    : TIMEOUT_CYCLES;
  localparam int unsigned TW = $clog2(TMax + 1);
  localparam logic [TW-1:0] InhibitLast = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StInhibit = 3'd1;
  localparam logic [2:0] StReq     = 3'd2;
  localparam logic [2:0] StBits    = 3'd3;
  localparam logic [2:0] StAck     = 3'd4;
  localparam logic [2:0] StRelease = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    edge_cnt_q, edge_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          dat_meta_q, dat_sync_q;
  logic          clk_fall;
  logic          abort;

  assign clk_fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    data_d     = data_q;
    parity_d   = parity_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    abort      = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        timer_d  = '0;
        // A request coinciding with the completion pulse belongs to the old transfer.
        if (send && !done_q && !error_q) begin
          data_d   = data;
          parity_d = ~^data;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = StInhibit;
        end
      end
      StInhibit: begin
        if (timer_q == InhibitLast) begin
          timer_d  = '0;
          dat_oe_d = 1'b1;
          state_d  = StReq;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StReq: begin
        clk_oe_d   = 1'b0;
        dat_oe_d   = 1'b1;
        edge_cnt_d = '0;
        timer_d    = '0;
        state_d    = StBits;
      end
      StBits: begin
        if (clk_fall) begin
          timer_d    = '0;
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (edge_cnt_q < 4'd8) begin
            dat_oe_d = ~data_q[edge_cnt_q[2:0]];
          end else if (edge_cnt_q == 4'd8) begin
            dat_oe_d = ~parity_q;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = StAck;
          end
        end else if (timer_q == TimeoutLast) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StAck: begin
        if (clk_fall) begin
          timer_d = '0;
          if (!dat_sync_q) begin
            state_d = StRelease;
          end else begin
            error_d  = 1'b1;
            busy_d   = 1'b0;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = StIdle;
          end
        end else if (timer_q == TimeoutLast) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StRelease: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (clk_fall) begin
          timer_d = '0;
        end else if (timer_q == TimeoutLast) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort) begin
      error_d  = 1'b1;
      busy_d   = 1'b0;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      timer_d  = '0;
      state_d  = StIdle;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      edge_cnt_q <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      edge_cnt_q <= edge_cnt_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clock-low inhibit time in clk cycles (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, maximum clk cycles between device clock falling edges (15 ms at 50 MHz).
REQ-003 The block SHALL have the following ports:
- clk  input  1  system clock, 50 MHz, all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- send  input  1  single-cycle request to transmit data.
- data  input  8  command byte, sampled when send is accepted.
- busy  output  1  high from send acceptance until done or error.
- done  output  1  one-cycle pulse when the device acknowledges.
- error  output  1  one-cycle pulse on missing ACK or timeout.
- ps2_clk_in  input  1  PS2 clock line level, asynchronous.
- ps2_dat_in  input  1  PS2 data line level, asynchronous.
- ps2_clk_oe  output  1  1 = drive PS2 clock low, 0 = release.
- ps2_dat_oe  output  1  1 = drive PS2 data low, 0 = release.

Function
REQ-004 The block SHALL pass ps2_clk_in and ps2_dat_in through 2-flop synchronizers; all protocol decisions use synchronized values only.
REQ-005 A falling edge SHALL be detected as synchronized clock 1 in the previous cycle and 0 in the current cycle.
REQ-006 The state machine SHALL use the states IDLE, INHIBIT, REQ, BITS, ACK, RELEASE.
REQ-007 IDLE: when send=1, the block SHALL latch data, compute odd parity (~^data), set busy=1, and go to INHIBIT in the next cycle.
REQ-008 send SHALL be ignored while busy=1.
REQ-009 INHIBIT: ps2_clk_oe=1 and ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
REQ-010 REQ: ps2_clk_oe=1 and ps2_dat_oe=1 for 1 cycle, then go to BITS with ps2_clk_oe=0 and ps2_dat_oe=1 (start bit).
REQ-011 BITS: on device clock falling edges 1..8, ps2_dat_oe SHALL be set to ~data[n-1] (LSB first); on edge 9, to ~parity; on edge 10, to 0 (stop bit released).
REQ-012 Edges SHALL be counted with a 4-bit counter that clears on entry to BITS; the count reaching 10 SHALL move the FSM to ACK.
REQ-013 ACK: on falling edge 11, synchronized data=0 SHALL move the FSM to RELEASE; synchronized data=1 SHALL pulse error and return to IDLE.
REQ-014 RELEASE: when both synchronized lines are 1, the block SHALL pulse done, drop busy in the same cycle, and return to IDLE.
REQ-015 In BITS, ACK and RELEASE, a timeout counter SHALL clear on every falling edge (and on entry to RELEASE); reaching TIMEOUT_CYCLES SHALL pulse error, clear busy, release both lines and return to IDLE.
REQ-016 busy SHALL drop in the same cycle that done or error pulses; done and error SHALL never be high in the same cycle.
REQ-017 In IDLE both oe outputs SHALL be 0; send in the same cycle as done or error SHALL be ignored.
REQ-018 Line changes SHALL occur only on detected falling edges; the block SHALL never drive ps2_dat_oe while the device clock is high except during REQ and the start bit.

Reset
REQ-019 resetn=0 SHALL force, asynchronously, state IDLE, busy=0, done=0, error=0, ps2_clk_oe=0, ps2_dat_oe=0, and all counters, synchronizers (to 1) and the data/parity registers to 0.
REQ-020 Reset asserted mid-transfer SHALL release both lines immediately, with no done or error pulse.

Verification
REQ-021 Send 0xED with a device model that ACKs -> clk_oe low 5000 cycles; dat bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; busy drops.
REQ-022 Send 0xFF -> parity bit 1 on line (dat_oe=0 on edge 9), done pulses.
REQ-023 Device holds data high on edge 11 -> error pulses, done stays 0, lines released.
REQ-024 Device never clocks after REQ -> error exactly TIMEOUT_CYCLES after the start bit, busy drops.
REQ-025 Second send pulse during a transfer of 0x00 -> ignored; only 0x00 is transmitted, with a single done pulse.
REQ-026 resetn low during bit 4 -> both oe outputs 0 immediately, busy 0, no pulses; a new send after reset completes normally.
